// File: rtl/seq_mul_div_unit_if.sv
// rtl/seq_mul_div_unit_if.sv - request/result bundle between control sequencer and seq_mul_div_unit
// Signals (master = sequencer, slave = engine):
//   start        m->s  request, sampled only while the engine is idle
//   mul_bar      m->s  0 = multiply, 1 = divide; sampled with start
//   a, b         m->s  multiplicand/dividend, multiplier/divisor; sampled with start
//   busy         s->m  operation in flight
//   done         s->m  one-cycle pulse, results valid
//   result_hi    s->m  product upper half / remainder
//   result_lo    s->m  product lower half / quotient
//   div_by_zero  s->m  divide with b == 0; held until the next accepted start
interface seq_mul_div_unit_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic             mul_bar;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result_hi;
  logic [WIDTH-1:0] result_lo;
  logic             div_by_zero;

  modport master (
    output start, mul_bar, a, b,
    input  busy, done, result_hi, result_lo, div_by_zero
  );

  modport slave (
    input  start, mul_bar, a, b,
    output busy, done, result_hi, result_lo, div_by_zero
  );
endinterface

// File: rtl/seq_mul_div_unit.sv
// rtl/seq_mul_div_unit.sv - iterative shift-add multiply / restoring divide engine, one step per clock
// Ports:
//   clk  in   rising-edge clock
//   rst  in   asynchronous reset, active-high
//   bus  slave modport of seq_mul_div_unit_if (start/mul_bar/a/b in, busy/done/results out)
// Configuration:
//   MDU_SIGNED_EN  defined: two's complement operands/results (magnitudes in the core,
//                  signs fixed in FIX); undefined: purely unsigned, no sign logic.
module seq_mul_div_unit #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  seq_mul_div_unit_if.slave  bus
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             op_div_q, op_div_d;
  logic             zero_q, zero_d;      // current op is a divide by zero
  logic [WIDTH-1:0] hi_q, hi_d;          // accumulator / partial remainder
  logic [WIDTH-1:0] lo_q, lo_d;          // multiplier / dividend, becomes product low / quotient
  logic [WIDTH-1:0] opb_q, opb_d;        // multiplicand / divisor
  logic [WIDTH-1:0] res_hi_q, res_hi_d;
  logic [WIDTH-1:0] res_lo_q, res_lo_d;
  logic             done_q, done_d;
  logic             dbz_q, dbz_d;
`ifdef MDU_SIGNED_EN
  logic             neg_q, neg_d;        // product / quotient must be negated
  logic             rneg_q, rneg_d;      // remainder must be negated (dividend negative)
  logic [2*WIDTH-1:0] prod_neg;
`endif

  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH+1:0] div_diff;
  logic             div_fits;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      op_div_q <= 1'b0;
      zero_q   <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      opb_q    <= '0;
      res_hi_q <= '0;
      res_lo_q <= '0;
      done_q   <= 1'b0;
      dbz_q    <= 1'b0;
`ifdef MDU_SIGNED_EN
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_div_q <= op_div_d;
      zero_q   <= zero_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      opb_q    <= opb_d;
      res_hi_q <= res_hi_d;
      res_lo_q <= res_lo_d;
      done_q   <= done_d;
      dbz_q    <= dbz_d;
`ifdef MDU_SIGNED_EN
      neg_q    <= neg_d;
      rneg_q   <= rneg_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_div_d = op_div_q;
    zero_d   = zero_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    opb_d    = opb_q;
    res_hi_d = res_hi_q;
    res_lo_d = res_lo_q;
    done_d   = 1'b0;
    dbz_d    = dbz_q;
`ifdef MDU_SIGNED_EN
    neg_d    = neg_q;
    rneg_d   = rneg_q;
    a_mag    = bus.a[WIDTH-1] ? (~bus.a + 1'b1) : bus.a;
    b_mag    = bus.b[WIDTH-1] ? (~bus.b + 1'b1) : bus.b;
    prod_neg = ~{hi_q, lo_q} + 1'b1;
`else
    a_mag    = bus.a;
    b_mag    = bus.b;
`endif

    // Multiply step: conditionally add multiplicand, shift {carry, hi, lo} right by one.
    mul_sum   = {1'b0, hi_q} + ({(WIDTH+1){lo_q[0]}} & {1'b0, opb_q});
    // Divide step: shift next dividend bit into the partial remainder, trial-subtract.
    // The remainder stays below the divisor, so a non-negative difference always fits
    // in WIDTH bits; anything in the top two bits means the subtraction borrowed.
    div_shift = {hi_q, lo_q[WIDTH-1]};
    div_diff  = {1'b0, div_shift} - {2'b00, opb_q};
    div_fits  = (div_diff[WIDTH+1:WIDTH] == 2'b00);

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          op_div_d = bus.mul_bar;
          dbz_d    = 1'b0;
          cnt_d    = CW'(WIDTH);
          hi_d     = '0;
`ifdef MDU_SIGNED_EN
          neg_d    = bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
          rneg_d   = bus.a[WIDTH-1];
`endif
          if (bus.mul_bar) begin
            opb_d = b_mag;
            lo_d  = a_mag;
          end else begin
            opb_d = a_mag;
            lo_d  = b_mag;
          end
          if (bus.mul_bar && (bus.b == '0)) begin
            // Divide by zero skips CALC; results are preloaded raw (no sign fix).
            zero_d  = 1'b1;
            hi_d    = bus.a;
            lo_d    = '1;
            state_d = S_FIX;
          end else begin
            zero_d  = 1'b0;
            state_d = S_CALC;
          end
        end
      end

      S_CALC: begin
        cnt_d = cnt_q - CW'(1);
        if (op_div_q) begin
          hi_d = div_fits ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
          lo_d = {lo_q[WIDTH-2:0], div_fits};
        end else begin
          hi_d = mul_sum[WIDTH:1];
          lo_d = {mul_sum[0], lo_q[WIDTH-1:1]};
        end
        if (cnt_q == CW'(1)) begin
          state_d = S_FIX;
        end
      end

      S_FIX: begin
        done_d   = 1'b1;
        dbz_d    = zero_q;
        res_hi_d = hi_q;
        res_lo_d = lo_q;
`ifdef MDU_SIGNED_EN
        if (!zero_q) begin
          if (op_div_q) begin
            if (neg_q)  res_lo_d = ~lo_q + 1'b1;
            if (rneg_q) res_hi_d = ~hi_q + 1'b1;
          end else if (neg_q) begin
            {res_hi_d, res_lo_d} = prod_neg;
          end
        end
`endif
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign bus.busy        = (state_q != S_IDLE);
  assign bus.done        = done_q;
  assign bus.result_hi   = res_hi_q;
  assign bus.result_lo   = res_lo_q;
  assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_mul_div_unit.sv
// tb/tb_seq_mul_div_unit.sv - directed self-checking bench for seq_mul_div_unit (WIDTH=8)
module tb_seq_mul_div_unit;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  seq_mul_div_unit_if #(.WIDTH(8)) bus ();

  seq_mul_div_unit #(.WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge with the engine idle; returns at the negedge after the accept edge.
  task automatic start_op(input logic mb, input logic [7:0] av, input logic [7:0] bv);
    bus.start   = 1'b1;
    bus.mul_bar = mb;
    bus.a       = av;
    bus.b       = bv;
    @(posedge clk);
    @(negedge clk);
    bus.start   = 1'b0;
    bus.mul_bar = ~mb;
    bus.a       = 8'($urandom);
    bus.b       = 8'($urandom);
  endtask

  // Counts edges until done is seen; returns at the negedge where done is high.
  task automatic wait_done(input string tag, input int exp_lat);
    int k;
    for (k = 1; k <= 40; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.done) break;
    end
    check({tag, "_latency"}, k, exp_lat);
  endtask

  task automatic do_op(input string tag, input logic mb, input logic [7:0] av, input logic [7:0] bv,
                       input int exp_lat, input logic [7:0] exp_hi, input logic [7:0] exp_lo,
                       input logic exp_dbz);
    start_op(mb, av, bv);
    check({tag, "_busy_run"}, bus.busy, 1'b1);
    wait_done(tag, exp_lat);
    check({tag, "_hi"}, bus.result_hi, exp_hi);
    check({tag, "_lo"}, bus.result_lo, exp_lo);
    check({tag, "_dbz"}, bus.div_by_zero, exp_dbz);
    check({tag, "_busy_done"}, bus.busy, 1'b0);
  endtask

  initial begin
    int n_done;
    rst         = 1'b1;
    bus.start   = 1'b0;
    bus.mul_bar = 1'b0;
    bus.a       = '0;
    bus.b       = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_done", bus.done, 1'b0);
    check("rst_hi", bus.result_hi, 8'h00);
    check("rst_lo", bus.result_lo, 8'h00);
    check("rst_dbz", bus.div_by_zero, 1'b0);
    rst = 1'b0;
    @(negedge clk);

    // 13 * 11 = 143
    do_op("mul13x11", 1'b0, 8'd13, 8'd11, 9, 8'h00, 8'h8F, 1'b0);
    @(negedge clk);
    check("mul13x11_done_pulse", bus.done, 1'b0);
    check("mul13x11_hold_lo", bus.result_lo, 8'h8F);

    // 255 * 255 = 0xFE01, then divide started in the very cycle done is high
    do_op("mulff", 1'b0, 8'hFF, 8'hFF, 9, 8'hFE, 8'h01, 1'b0);
    do_op("div200by7", 1'b1, 8'd200, 8'd7, 9, 8'h04, 8'h1C, 1'b0);

    // divide by zero
    do_op("div5Aby0", 1'b1, 8'h5A, 8'h00, 1, 8'h5A, 8'hFF, 1'b1);
    @(negedge clk);
    check("dbz_held", bus.div_by_zero, 1'b1);
    start_op(1'b0, 8'd2, 8'd3);
    check("dbz_clear_on_start", bus.div_by_zero, 1'b0);
    wait_done("mul2x3", 9);
    check("mul2x3_lo", bus.result_lo, 8'h06);
    @(negedge clk);

    // second start mid-CALC must be ignored: 0x12 * 0x34 = 0x03A8
    start_op(1'b0, 8'h12, 8'h34);
    @(posedge clk);
    @(negedge clk);
    bus.start   = 1'b1;
    bus.mul_bar = 1'b1;
    bus.a       = 8'hFF;
    bus.b       = 8'hFF;
    @(posedge clk);
    @(negedge clk);
    bus.start   = 1'b0;
    wait_done("ignore_start", 7);
    check("ignore_start_hi", bus.result_hi, 8'h03);
    check("ignore_start_lo", bus.result_lo, 8'hA8);
    n_done = 0;
    repeat (12) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.done) n_done++;
    end
    check("ignore_start_single_done", n_done, 0);
    check("ignore_start_idle", bus.busy, 1'b0);

    // reset in the 4th CALC cycle
    start_op(1'b0, 8'd100, 8'd100);
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
    end
    rst = 1'b1;
    #1;
    check("midrst_busy", bus.busy, 1'b0);
    check("midrst_hi", bus.result_hi, 8'h00);
    check("midrst_lo", bus.result_lo, 8'h00);
    check("midrst_done", bus.done, 1'b0);
    n_done = 0;
    repeat (12) begin
      @(negedge clk);
      if (bus.done) n_done++;
    end
    check("midrst_no_done", n_done, 0);
    rst = 1'b0;
    @(negedge clk);
    do_op("div250by9", 1'b1, 8'd250, 8'd9, 9, 8'h07, 8'h1B, 1'b0);

    // boundary operands
    do_op("mul_by0", 1'b0, 8'hAB, 8'h00, 9, 8'h00, 8'h00, 1'b0);
    do_op("div_small", 1'b1, 8'd7, 8'd9, 9, 8'h07, 8'h00, 1'b0);
    do_op("div_by1", 1'b1, 8'hFF, 8'h01, 9, 8'h00, 8'hFF, 1'b0);
    do_op("div_eq", 1'b1, 8'h80, 8'h80, 9, 8'h00, 8'h01, 1'b0);

`ifdef MDU_SIGNED_EN
    do_op("smul_m7x3", 1'b0, 8'hF9, 8'h03, 9, 8'hFF, 8'hEB, 1'b0);
    do_op("sdiv_m7by2", 1'b1, 8'hF9, 8'h02, 9, 8'hFF, 8'hFD, 1'b0);
    do_op("sdiv_minby_m1", 1'b1, 8'h80, 8'hFF, 9, 8'h00, 8'h80, 1'b0);
    do_op("smul_m1xm1", 1'b0, 8'hFF, 8'hFF, 9, 8'h00, 8'h01, 1'b0);
    do_op("sdiv_7by_m2", 1'b1, 8'h07, 8'hFE, 9, 8'h01, 8'hFD, 1'b0);
    do_op("sdiv_by0", 1'b1, 8'hF9, 8'h00, 1, 8'hF9, 8'hFF, 1'b1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
